// File: rtl/reg_writeback_ctrl.sv
// Register-file writer: merges the single-cycle ALU path and a buffered multi-cycle
// path onto one registered write port, and forwards the newest pending value to reads.
module reg_writeback_ctrl #(
  parameter int ADDR_LEN     = 3,
  parameter int DATA_WIDTH   = 16,
  parameter int MC_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  ex_valid,
  input  logic [ADDR_LEN-1:0]   ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_data,
  output logic                  ex_stall,
  input  logic                  mc_valid,
  input  logic [ADDR_LEN-1:0]   mc_rd,
  input  logic [DATA_WIDTH-1:0] mc_data,
  output logic                  mc_ready,
  output logic                  Reg_W_En,
  output logic [ADDR_LEN-1:0]   Rd,
  output logic [DATA_WIDTH-1:0] writedata,
  input  logic [ADDR_LEN-1:0]   Rs1,
  input  logic [ADDR_LEN-1:0]   Rs2,
  input  logic [DATA_WIDTH-1:0] RD1,
  input  logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int IDX_W = (MC_DEPTH > 1) ? $clog2(MC_DEPTH) : 1;

  // Buffer is kept compacted: slot 0 is the oldest entry and every set live bit is
  // contiguous from slot 0, so squashed entries vanish without costing port time.
  logic [ADDR_LEN-1:0]   buf_rd   [MC_DEPTH];
  logic [DATA_WIDTH-1:0] buf_data [MC_DEPTH];
  logic [MC_DEPTH-1:0]   buf_live;
  logic [CNT_W-1:0]      starve_cnt;

  logic [ADDR_LEN-1:0]   nxt_rd   [MC_DEPTH];
  logic [DATA_WIDTH-1:0] nxt_data [MC_DEPTH];
  logic [MC_DEPTH-1:0]   nxt_live;
  logic [CNT_W-1:0]      nxt_cnt;

  logic                  full;
  logic                  empty;
  logic                  ex_wr;
  logic                  mc_take;
  logic                  sel_en;
  logic [ADDR_LEN-1:0]   sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  pop;
  logic                  push;

  assign full     = &buf_live;
  assign empty    = !buf_live[0];
  assign mc_ready = !full;
  assign ex_stall = (starve_cnt == CNT_W'(STARVE_LIMIT)) && !empty;
  assign ex_wr    = ex_valid && !ex_stall && (ex_rd != '0);
  // The ALU write is younger, so a same-cycle mc result to the same register is dropped.
  assign mc_take  = mc_valid && mc_ready && (mc_rd != '0) && !(ex_wr && (mc_rd == ex_rd));

  always_comb begin
    sel_en   = 1'b0;
    sel_rd   = Rd;
    sel_data = writedata;
    pop      = 1'b0;
    push     = 1'b0;
    if (ex_wr) begin
      sel_en   = 1'b1;
      sel_rd   = ex_rd;
      sel_data = ex_data;
      push     = mc_take;
    end else if (!empty) begin
      sel_en   = 1'b1;
      sel_rd   = buf_rd[0];
      sel_data = buf_data[0];
      pop      = 1'b1;
      push     = mc_take;
    end else if (mc_take) begin
      sel_en   = 1'b1;
      sel_rd   = mc_rd;
      sel_data = mc_data;
    end
  end

  always_comb begin
    int n_keep;
    nxt_rd   = buf_rd;
    nxt_data = buf_data;
    nxt_live = '0;
    n_keep   = 0;
    for (int i = 0; i < MC_DEPTH; i++) begin
      if (buf_live[i] && !(pop && (i == 0)) && !(ex_wr && (buf_rd[i] == ex_rd))) begin
        nxt_rd[IDX_W'(n_keep)]   = buf_rd[i];
        nxt_data[IDX_W'(n_keep)] = buf_data[i];
        nxt_live[IDX_W'(n_keep)] = 1'b1;
        n_keep++;
      end
    end
    if (push && (n_keep < MC_DEPTH)) begin
      nxt_rd[IDX_W'(n_keep)]   = mc_rd;
      nxt_data[IDX_W'(n_keep)] = mc_data;
      nxt_live[IDX_W'(n_keep)] = 1'b1;
    end
    nxt_cnt = (ex_wr && (n_keep != 0)) ? starve_cnt + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      Reg_W_En   <= 1'b0;
      Rd         <= '0;
      writedata  <= '0;
      buf_live   <= '0;
      starve_cnt <= '0;
      for (int i = 0; i < MC_DEPTH; i++) begin
        buf_rd[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      Reg_W_En <= sel_en;
      if (sel_en) begin
        Rd        <= sel_rd;
        writedata <= sel_data;
      end
      buf_rd     <= nxt_rd;
      buf_data   <= nxt_data;
      buf_live   <= nxt_live;
      starve_cnt <= nxt_cnt;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] fwd(input logic [ADDR_LEN-1:0] rs,
                                                 input logic [DATA_WIDTH-1:0] raw);
    logic [DATA_WIDTH-1:0] val;
    val = raw;
    if (Reg_W_En && (Rd == rs)) val = writedata;
    for (int i = 0; i < MC_DEPTH; i++) begin
      if (buf_live[i] && (buf_rd[i] == rs)) val = buf_data[i];
    end
    if (rs == '0) val = '0;
    return val;
  endfunction

  always_comb op1 = fwd(Rs1, RD1);
  always_comb op2 = fwd(Rs2, RD2);

endmodule
